// File: rtl/uart_ram_bundle_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_ram_bundle_if : serial PHY handshake and RAM bus for uart_ram_bundle |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface uart_ram_bundle_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
);
  logic                  rx;
  logic                  tx;
  logic                  trmt;
  logic [ADDR_WIDTH-1:0] tx_data;
  logic                  tx_done;
  logic                  clr_tx_done;
  logic [ADDR_WIDTH-1:0] rx_data;
  logic                  rx_done;
  logic                  clr_rx_done;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] mem_debug [0:2**ADDR_WIDTH-1];

  modport master (
    output rx, trmt, tx_data, clr_tx_done, clr_rx_done, wr, addr, wdata,
    input  tx, tx_done, rx_data, rx_done, rdata, mem_debug
  );

  modport slave (
    input  rx, trmt, tx_data, clr_tx_done, clr_rx_done, wr, addr, wdata,
    output tx, tx_done, rx_data, rx_done, rdata, mem_debug
  );
endinterface
`default_nettype wire

// File: rtl/uart_ram_bundle.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_ram_bundle : UART transmitter, UART receiver and debug-visible RAM   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module uart_ram_bundle #(
  parameter int ADDR_WIDTH  = 1,
  parameter int DATA_WIDTH  = 1,
  parameter int BAUD_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  uart_ram_bundle_if.slave bus
);
  localparam int c_cnt_w = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
  localparam int c_bit_w = $clog2(ADDR_WIDTH + 2);
  localparam int c_half  = BAUD_PERIOD / 2;
  localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUD_PERIOD - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'((c_half > 0) ? c_half - 1 : 0);
  localparam logic [c_bit_w-1:0] c_tx_last   = c_bit_w'(ADDR_WIDTH + 1);
  localparam logic [c_bit_w-1:0] c_rx_last   = c_bit_w'(ADDR_WIDTH - 1);

  localparam logic [0:0] c_tx_idle = 1'b0;
  localparam logic [0:0] c_tx_xmit = 1'b1;

  localparam logic [1:0] c_rx_idle  = 2'd0;
  localparam logic [1:0] c_rx_start = 2'd1;
  localparam logic [1:0] c_rx_data  = 2'd2;
  localparam logic [1:0] c_rx_stop  = 2'd3;

  // ---------------- transmitter ----------------
  logic [0:0]            r_tx_state, w_tx_state_nxt;
  logic [c_cnt_w-1:0]    r_tx_baud;
  logic [c_bit_w-1:0]    r_tx_bit;
  logic [ADDR_WIDTH+1:0] r_tx_shift;
  logic                  r_tx_done;
  logic                  w_tx_start, w_tx_bit_end, w_tx_frame_end;

  always_ff @(posedge clk) begin
    if (!rst_l) r_tx_state <= c_tx_idle;
    else        r_tx_state <= w_tx_state_nxt;
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      c_tx_idle: if (w_tx_start)     w_tx_state_nxt = c_tx_xmit;
      default:   if (w_tx_frame_end) w_tx_state_nxt = c_tx_idle;
    endcase
  end

  always_comb begin
    w_tx_start     = (r_tx_state == c_tx_idle) && bus.trmt;
    w_tx_bit_end   = (r_tx_state == c_tx_xmit) && (r_tx_baud == c_baud_last);
    w_tx_frame_end = w_tx_bit_end && (r_tx_bit == c_tx_last);
    bus.tx         = (r_tx_state == c_tx_xmit) ? r_tx_shift[0] : 1'b1;
  end

  // Frame is shifted out LSB first: start bit sits in bit 0, stop bit on top.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
      r_tx_done  <= 1'b0;
    end else begin
      if (w_tx_start) begin
        r_tx_shift <= {1'b1, bus.tx_data, 1'b0};
        r_tx_baud  <= '0;
        r_tx_bit   <= '0;
      end else if (w_tx_bit_end) begin
        r_tx_shift <= {1'b1, r_tx_shift[ADDR_WIDTH+1:1]};
        r_tx_baud  <= '0;
        r_tx_bit   <= r_tx_bit + 1'b1;
      end else if (r_tx_state == c_tx_xmit) begin
        r_tx_baud  <= r_tx_baud + 1'b1;
      end
      if (w_tx_frame_end)                    r_tx_done <= 1'b1;
      else if (w_tx_start || bus.clr_tx_done) r_tx_done <= 1'b0;
    end
  end

  assign bus.tx_done = r_tx_done;

  // ---------------- receiver ----------------
  logic                  r_rx_s1, r_rx_s2;
  logic [1:0]            r_rx_state, w_rx_state_nxt;
  logic [c_cnt_w-1:0]    r_rx_cnt;
  logic [c_bit_w-1:0]    r_rx_bit;
  logic [ADDR_WIDTH-1:0] r_rx_shift;
  logic [ADDR_WIDTH-1:0] r_rx_data;
  logic                  r_rx_done;
  logic                  w_rx_sample, w_rx_good;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= c_rx_idle;
    end else begin
      r_rx_s1    <= bus.rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_state_nxt;
    end
  end

  // With BAUD_PERIOD of 1 there is no half-bit to wait, so go straight to DATA.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      c_rx_idle:  if (!r_rx_s2) w_rx_state_nxt = (c_half == 0) ? c_rx_data : c_rx_start;
      c_rx_start: if (w_rx_sample) w_rx_state_nxt = r_rx_s2 ? c_rx_idle : c_rx_data;
      c_rx_data:  if (w_rx_sample && (r_rx_bit == c_rx_last)) w_rx_state_nxt = c_rx_stop;
      default:    if (w_rx_sample) w_rx_state_nxt = c_rx_idle;
    endcase
  end

  always_comb begin
    case (r_rx_state)
      c_rx_start: w_rx_sample = (r_rx_cnt == c_half_last);
      c_rx_data,
      c_rx_stop:  w_rx_sample = (r_rx_cnt == c_baud_last);
      default:    w_rx_sample = 1'b0;
    endcase
    w_rx_good = (r_rx_state == c_rx_stop) && w_rx_sample && r_rx_s2;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      if ((r_rx_state == c_rx_idle) || w_rx_sample) r_rx_cnt <= '0;
      else                                          r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state != c_rx_data) r_rx_bit <= '0;
      else if (w_rx_sample)        r_rx_bit <= r_rx_bit + 1'b1;
      if ((r_rx_state == c_rx_data) && w_rx_sample)
        r_rx_shift <= ADDR_WIDTH'({r_rx_s2, r_rx_shift} >> 1);
      if (w_rx_good) r_rx_data <= r_rx_shift;
      if (w_rx_good)            r_rx_done <= 1'b1;
      else if (bus.clr_rx_done) r_rx_done <= 1'b0;
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.rx_done = r_rx_done;

  // ---------------- RAM ----------------
  logic [DATA_WIDTH-1:0] r_mem [0:2**ADDR_WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) r_mem[i] <= '0;
    end else if (bus.wr) begin
      r_mem[bus.addr] <= bus.wdata;
    end
  end

  assign bus.rdata = r_mem[bus.addr];

  for (genvar i = 0; i < 2**ADDR_WIDTH; i++) begin : g_debug
    assign bus.mem_debug[i] = r_mem[i];
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_ram_bundle.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_ram_bundle : directed self-checking bench for uart_ram_bundle     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_uart_ram_bundle;
  logic clk = 1'b0;
  logic rst_l;
  logic loop_en;
  logic rx_drv;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_ram_bundle_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
  assign bus.rx = loop_en ? bus.tx : rx_drv;

  uart_ram_bundle #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BAUD_PERIOD(4)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx_done(output bit ok);
    int n = 0;
    while (bus.rx_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    ok = (bus.rx_done === 1'b1);
  endtask

  task automatic wait_tx_done(output bit ok);
    int n = 0;
    while (bus.tx_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    ok = (bus.tx_done === 1'b1);
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (4) tick();
    end
    rx_drv = stop;
    repeat (4) tick();
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_l = 1'b0;
    repeat (2) tick();
    tests++; if (bus.tx !== 1'b1)      begin fails++; $display("FAIL reset_tx got %b want 1", bus.tx); end
    tests++; if (bus.tx_done !== 1'b0) begin fails++; $display("FAIL reset_tx_done got %b want 0", bus.tx_done); end
    tests++; if (bus.rx_done !== 1'b0) begin fails++; $display("FAIL reset_rx_done got %b want 0", bus.rx_done); end
    tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got %h want 00", bus.rx_data); end
    for (int i = 0; i < 256; i++) if (bus.mem_debug[i] !== 8'h00) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL reset_mem nonzero entries %0d want 0", bad); end
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_tx_frame();
    logic [9:0] exp_bits = 10'b11_0100_1010;
    bus.tx_data = 8'hA5;
    bus.trmt    = 1'b1;
    tick();
    bus.trmt    = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        tests++;
        if (bus.tx !== exp_bits[b] || bus.tx_done !== 1'b0) begin
          fails++;
          $display("FAIL tx_bit%0d_cyc%0d got tx=%b done=%b want tx=%b done=0", b, c, bus.tx, bus.tx_done, exp_bits[b]);
        end
        tick();
      end
    end
    tests++; if (bus.tx_done !== 1'b1) begin fails++; $display("FAIL tx_done_at_40 got %b want 1", bus.tx_done); end
    repeat (2) tick();
    tests++; if (bus.tx_done !== 1'b1 || bus.tx !== 1'b1) begin fails++; $display("FAIL tx_done_sticky got done=%b tx=%b want 1 1", bus.tx_done, bus.tx); end
    bus.clr_tx_done = 1'b1;
    tick();
    bus.clr_tx_done = 1'b0;
    tests++; if (bus.tx_done !== 1'b0) begin fails++; $display("FAIL tx_done_clear got %b want 0", bus.tx_done); end
  endtask

  task automatic test_loopback();
    bit ok;
    loop_en = 1'b1;
    tick();
    bus.tx_data = 8'h3C;
    bus.trmt    = 1'b1;
    tick();
    bus.trmt    = 1'b0;
    wait_rx_done(ok);
    tests++; if (!ok || bus.rx_data !== 8'h3C) begin fails++; $display("FAIL loop_3c got done=%b data=%h want 1 3c", ok, bus.rx_data); end
    bus.clr_rx_done = 1'b1;
    bus.clr_tx_done = 1'b1;
    tick();
    bus.clr_rx_done = 1'b0;
    bus.clr_tx_done = 1'b0;
    tests++; if (bus.rx_done !== 1'b0) begin fails++; $display("FAIL loop_clr_rx got %b want 0", bus.rx_done); end
    repeat (2) tick();
    // Back-to-back: trmt stays high across the first tx_done.
    bus.tx_data = 8'h00;
    bus.trmt    = 1'b1;
    tick();
    bus.tx_data = 8'hFF;
    wait_tx_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL loop_tx_done0 got timeout want 1"); end
    bus.clr_tx_done = 1'b1;
    tick();
    bus.clr_tx_done = 1'b0;
    bus.trmt        = 1'b0;
    tests++; if (bus.tx !== 1'b0 || bus.tx_done !== 1'b0) begin fails++; $display("FAIL loop_b2b_start got tx=%b done=%b want 0 0", bus.tx, bus.tx_done); end
    wait_rx_done(ok);
    tests++; if (!ok || bus.rx_data !== 8'h00) begin fails++; $display("FAIL loop_00 got done=%b data=%h want 1 00", ok, bus.rx_data); end
    bus.clr_rx_done = 1'b1;
    tick();
    bus.clr_rx_done = 1'b0;
    tests++; if (bus.rx_done !== 1'b0) begin fails++; $display("FAIL loop_once_00 got %b want 0", bus.rx_done); end
    wait_rx_done(ok);
    tests++; if (!ok || bus.rx_data !== 8'hFF) begin fails++; $display("FAIL loop_ff got done=%b data=%h want 1 ff", ok, bus.rx_data); end
    bus.clr_rx_done = 1'b1;
    bus.clr_tx_done = 1'b1;
    tick();
    bus.clr_rx_done = 1'b0;
    bus.clr_tx_done = 1'b0;
    repeat (4) tick();
    tests++; if (bus.rx_done !== 1'b0 || bus.tx_done !== 1'b0) begin fails++; $display("FAIL loop_idle_flags got rx=%b tx=%b want 0 0", bus.rx_done, bus.tx_done); end
    loop_en = 1'b0;
  endtask

  task automatic test_ram();
    int bad = 0;
    bus.wr    = 1'b1;
    bus.addr  = 8'h12;
    bus.wdata = 8'h5A;
    tick();
    bus.wr    = 1'b0;
    bus.wdata = 8'hC3;
    tests++; if (bus.rdata !== 8'h5A) begin fails++; $display("FAIL ram_rdata got %h want 5a", bus.rdata); end
    tests++; if (bus.mem_debug[8'h12] !== 8'h5A) begin fails++; $display("FAIL ram_debug12 got %h want 5a", bus.mem_debug[8'h12]); end
    for (int i = 0; i < 256; i++) if (i != 8'h12 && bus.mem_debug[i] !== 8'h00) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL ram_others nonzero entries %0d want 0", bad); end
    tick();
    tests++; if (bus.rdata !== 8'h5A) begin fails++; $display("FAIL ram_no_write got %h want 5a", bus.rdata); end
    bus.addr = 8'hFF;
    #1;
    tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL ram_rd_ff got %h want 00", bus.rdata); end
    bus.wr    = 1'b1;
    bus.wdata = 8'h81;
    tick();
    bus.wr    = 1'b0;
    tests++; if (bus.rdata !== 8'h81 || bus.mem_debug[255] !== 8'h81) begin fails++; $display("FAIL ram_top got rdata=%h dbg=%h want 81 81", bus.rdata, bus.mem_debug[255]); end
  endtask

  task automatic test_rx_errors();
    bit ok;
    send_rx_frame(8'h77, 1'b0);
    repeat (12) tick();
    tests++; if (bus.rx_done !== 1'b0 || bus.rx_data !== 8'hFF) begin fails++; $display("FAIL rx_framing got done=%b data=%h want 0 ff", bus.rx_done, bus.rx_data); end
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (6) tick();
    tests++; if (bus.rx_done !== 1'b0) begin fails++; $display("FAIL rx_glitch got done=%b want 0", bus.rx_done); end
    send_rx_frame(8'h81, 1'b1);
    wait_rx_done(ok);
    tests++; if (!ok || bus.rx_data !== 8'h81) begin fails++; $display("FAIL rx_after_glitch got done=%b data=%h want 1 81", ok, bus.rx_data); end
    bus.clr_rx_done = 1'b1;
    tick();
    bus.clr_rx_done = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int seen = 0;
    loop_en = 1'b1;
    tick();
    bus.tx_data = 8'hA5;
    bus.trmt    = 1'b1;
    tick();
    bus.trmt    = 1'b0;
    repeat (17) tick();
    rst_l = 1'b0;
    tick();
    tests++; if (bus.tx !== 1'b1 || bus.tx_done !== 1'b0) begin fails++; $display("FAIL midrst_tx got tx=%b done=%b want 1 0", bus.tx, bus.tx_done); end
    rst_l = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (bus.rx_done !== 1'b0 || bus.tx_done !== 1'b0) seen++;
      tick();
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL midrst_flags got %0d flagged cycles want 0", seen); end
    tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL midrst_rx_data got %h want 00", bus.rx_data); end
    loop_en = 1'b0;
  endtask

  initial begin
    rst_l           = 1'b0;
    loop_en         = 1'b0;
    rx_drv          = 1'b1;
    bus.trmt        = 1'b0;
    bus.tx_data     = 8'h00;
    bus.clr_tx_done = 1'b0;
    bus.clr_rx_done = 1'b0;
    bus.wr          = 1'b0;
    bus.addr        = 8'h00;
    bus.wdata       = 8'h00;
    tick();
    test_reset();
    test_tx_frame();
    test_loopback();
    test_ram();
    test_rx_errors();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
